// File: rtl/decode_ctrl_stage.sv
// RV32I decode/control stage: decodes the IF/ID instruction into a control bundle,
// holds it in the ID/EX register and inserts load-use bubbles.
module decode_ctrl_stage #(
    parameter int LOAD_STALL     = 1,
    parameter bit ENABLE_SUBWORD = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] instr,
    output logic        in_ready,
    input  logic        flush,
    input  logic        ex_ready,
    output logic        out_valid,
    output logic        has_imm,
    output logic        rf_we,
    output logic        mem_we,
    output logic        mem2rf,
    output logic [2:0]  alu_op,
    output logic        alu_alt,
    output logic [1:0]  mem_size,
    output logic        mem_unsigned,
    output logic        branch,
    output logic        jal,
    output logic        jalr,
    output logic        lui,
    output logic        auipc,
    output logic [2:0]  br_cond,
    output logic        illegal,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2
);
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [1:0] STALL_INIT = 2'(LOAD_STALL - 1);

    typedef struct packed {
        logic       has_imm;
        logic       rf_we;
        logic       mem_we;
        logic       mem2rf;
        logic [2:0] alu_op;
        logic       alu_alt;
        logic [1:0] mem_size;
        logic       mem_unsigned;
        logic       branch;
        logic       jal;
        logic       jalr;
        logic       lui;
        logic       auipc;
        logic [2:0] br_cond;
        logic       illegal;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } ctrl_t;

    ctrl_t      dec;
    ctrl_t      held;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       known;
    logic       ls_bad;
    logic       hazard;
    logic       stall;
    logic [1:0] stall_cnt;
    logic [2:0] funct3;
    logic       unused_bits;

    assign funct3      = instr[14:12];
    assign unused_bits = ^{instr[31], instr[29:25]};

    always_comb begin
        dec      = '0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        known    = 1'b1;
        ls_bad   = 1'b0;
        dec.rd   = instr[11:7];
        dec.rs1  = instr[19:15];
        dec.rs2  = instr[24:20];
        case (instr[6:0])
            OPC_OP_IMM: begin
                dec.rf_we   = 1'b1;
                dec.has_imm = 1'b1;
                dec.alu_op  = funct3;
                dec.alu_alt = (funct3 == 3'b101) & instr[30];
                uses_rs1    = 1'b1;
            end
            OPC_OP: begin
                dec.rf_we   = 1'b1;
                dec.alu_op  = funct3;
                dec.alu_alt = ((funct3 == 3'b000) | (funct3 == 3'b101)) & instr[30];
                uses_rs1    = 1'b1;
                uses_rs2    = 1'b1;
            end
            OPC_LOAD: begin
                dec.has_imm      = 1'b1;
                dec.rf_we        = 1'b1;
                dec.mem2rf       = 1'b1;
                dec.mem_size     = funct3[1:0];
                dec.mem_unsigned = funct3[2];
                uses_rs1         = 1'b1;
                ls_bad = ENABLE_SUBWORD ? ((funct3 == 3'b011) | (funct3[2:1] == 2'b11))
                                        : (funct3 != 3'b010);
            end
            OPC_STORE: begin
                dec.has_imm  = 1'b1;
                dec.mem_we   = 1'b1;
                dec.mem_size = funct3[1:0];
                uses_rs1     = 1'b1;
                uses_rs2     = 1'b1;
                ls_bad = ENABLE_SUBWORD ? (funct3 >= 3'b011) : (funct3 != 3'b010);
            end
            OPC_BRANCH: begin
                dec.branch  = 1'b1;
                dec.br_cond = funct3;
                uses_rs1    = 1'b1;
                uses_rs2    = 1'b1;
            end
            OPC_JAL: begin
                dec.jal   = 1'b1;
                dec.rf_we = 1'b1;
            end
            OPC_JALR: begin
                dec.jalr    = 1'b1;
                dec.has_imm = 1'b1;
                dec.rf_we   = 1'b1;
                uses_rs1    = 1'b1;
            end
            OPC_LUI: begin
                dec.lui     = 1'b1;
                dec.rf_we   = 1'b1;
                dec.has_imm = 1'b1;
            end
            OPC_AUIPC: begin
                dec.auipc   = 1'b1;
                dec.rf_we   = 1'b1;
                dec.has_imm = 1'b1;
            end
            default: known = 1'b0;
        endcase
        dec.illegal = (instr[1:0] != 2'b11) | !known | ls_bad;
        if (dec.rd == 5'd0) dec.rf_we = 1'b0;
        // Illegal words still flow down the pipe but must have no side effects.
        if (dec.illegal) begin
            dec.rf_we  = 1'b0;
            dec.mem_we = 1'b0;
            dec.mem2rf = 1'b0;
            dec.branch = 1'b0;
            dec.jal    = 1'b0;
            dec.jalr   = 1'b0;
        end
    end

    assign hazard = in_valid & out_valid & held.mem2rf & (held.rd != 5'd0) &
                    ((uses_rs1 & (dec.rs1 == held.rd)) | (uses_rs2 & (dec.rs2 == held.rd)));
    assign stall    = hazard | (stall_cnt != 2'd0);
    assign in_ready = !stall & (!out_valid | ex_ready) & !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            stall_cnt <= 2'd0;
            held      <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            stall_cnt <= 2'd0;
        end else if (!out_valid || ex_ready) begin
            // The first bubble is emitted here; stall_cnt counts the remaining ones.
            if (hazard) begin
                out_valid <= 1'b0;
                stall_cnt <= STALL_INIT;
            end else if (stall_cnt != 2'd0) begin
                out_valid <= 1'b0;
                stall_cnt <= stall_cnt - 2'd1;
            end else if (in_valid) begin
                held      <= dec;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    assign has_imm      = held.has_imm;
    assign rf_we        = held.rf_we;
    assign mem_we       = held.mem_we;
    assign mem2rf       = held.mem2rf;
    assign alu_op       = held.alu_op;
    assign alu_alt      = held.alu_alt;
    assign mem_size     = held.mem_size;
    assign mem_unsigned = held.mem_unsigned;
    assign branch       = held.branch;
    assign jal          = held.jal;
    assign jalr         = held.jalr;
    assign lui          = held.lui;
    assign auipc        = held.auipc;
    assign br_cond      = held.br_cond;
    assign illegal      = held.illegal;
    assign rd           = held.rd;
    assign rs1          = held.rs1;
    assign rs2          = held.rs2;
endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Bench for decode_ctrl_stage: two instances (LOAD_STALL=2/subword off, LOAD_STALL=3/subword on)
// driven by the same inputs and checked against a cycle model.
module tb_decode_ctrl_stage;
    localparam int LS0 = 2;
    localparam int LS1 = 3;
    localparam logic [31:0] LW5  = 32'h0000A283;  // lw x5,0(x1)
    localparam logic [31:0] ADD6 = 32'h00228333;  // add x6,x5,x2

    typedef struct packed {
        logic ov, ill, hi, rw, mw, m2;
        logic [2:0] aop;
        logic aa;
        logic [1:0] ms;
        logic mu, br, jal, jalr, lui, aui;
        logic [2:0] brc;
        logic [4:0] rd, rs1, rs2;
    } bun_t;

    typedef struct {
        logic [31:0] ins;
        bit ill0, ill1, rf_we, mem_we, mem2rf, has_imm;
        logic [2:0] alu_op;
        bit alu_alt;
        logic [4:0] rd;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n, in_valid, flush, ex_ready;
    logic [31:0] instr;
    logic ir_w[2], ov_w[2], hi_w[2], rw_w[2], mw_w[2], m2_w[2], aa_w[2], mu_w[2];
    logic br_w[2], jal_w[2], jalr_w[2], lui_w[2], aui_w[2], ill_w[2];
    logic [2:0] aop_w[2], brc_w[2];
    logic [1:0] ms_w[2];
    logic [4:0] rd_w[2], rs1_w[2], rs2_w[2];
    bun_t act[2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        decode_ctrl_stage #(.LOAD_STALL(g == 0 ? LS0 : LS1), .ENABLE_SUBWORD(g == 1)) dut (
            .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .instr(instr), .in_ready(ir_w[g]),
            .flush(flush), .ex_ready(ex_ready), .out_valid(ov_w[g]), .has_imm(hi_w[g]),
            .rf_we(rw_w[g]), .mem_we(mw_w[g]), .mem2rf(m2_w[g]), .alu_op(aop_w[g]),
            .alu_alt(aa_w[g]), .mem_size(ms_w[g]), .mem_unsigned(mu_w[g]), .branch(br_w[g]),
            .jal(jal_w[g]), .jalr(jalr_w[g]), .lui(lui_w[g]), .auipc(aui_w[g]),
            .br_cond(brc_w[g]), .illegal(ill_w[g]), .rd(rd_w[g]), .rs1(rs1_w[g]), .rs2(rs2_w[g]));
        assign act[g] = {ov_w[g], ill_w[g], hi_w[g], rw_w[g], mw_w[g], m2_w[g], aop_w[g], aa_w[g],
                         ms_w[g], mu_w[g], br_w[g], jal_w[g], jalr_w[g], lui_w[g], aui_w[g],
                         brc_w[g], rd_w[g], rs1_w[g], rs2_w[g]};
    end

    int n_cmp = 0;
    int n_bad = 0;
    bit mv[2];
    logic [31:0] mins[2];
    int mblk[2];
    int cyc = 0;
    vec_t tbl[13];

    task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endtask

    function automatic int ls_of(input int d);
        return (d == 0) ? LS0 : LS1;
    endfunction

    // Expected bundle and care-mask straight from the opcode table.
    function automatic void mdec(input logic [31:0] i, input bit es, output bun_t e, output bun_t m);
        logic [2:0] f3;
        f3 = i[14:12];
        e = '0; m = '0;
        e.ov = 1'b1; e.rd = i[11:7]; e.rs1 = i[19:15]; e.rs2 = i[24:20];
        m.ov = 1'b1; m.ill = 1'b1; m.rw = 1'b1; m.mw = 1'b1; m.m2 = 1'b1;
        m.br = 1'b1; m.jal = 1'b1; m.jalr = 1'b1; m.rd = '1; m.rs1 = '1; m.rs2 = '1;
        case (i[6:0])
            7'h13: begin e.rw = 1; e.hi = 1; e.aop = f3; e.aa = (f3 == 5) && i[30]; end
            7'h33: begin e.rw = 1; e.aop = f3; e.aa = (f3 == 0 || f3 == 5) && i[30]; end
            7'h03: begin
                e.hi = 1; e.rw = 1; e.m2 = 1; e.ms = f3[1:0]; e.mu = f3[2];
                m.ms = '1; m.mu = 1;
                e.ill = es ? (f3 == 3 || f3 == 6 || f3 == 7) : (f3 != 2);
            end
            7'h23: begin
                e.hi = 1; e.mw = 1; e.ms = f3[1:0]; m.ms = '1;
                e.ill = es ? (f3 >= 3) : (f3 != 2);
            end
            7'h63: begin e.br = 1; e.brc = f3; m.brc = '1; end
            7'h6F: begin e.jal = 1; e.rw = 1; end
            7'h67: begin e.jalr = 1; e.hi = 1; e.rw = 1; end
            7'h37: begin e.lui = 1; e.rw = 1; e.hi = 1; end
            7'h17: begin e.aui = 1; e.rw = 1; e.hi = 1; end
            default: e.ill = 1;
        endcase
        if (e.rd == 0) e.rw = 0;
        if (e.ill) begin
            {e.rw, e.mw, e.m2, e.br, e.jal, e.jalr} = '0;
            m.ms = '0; m.mu = 0; m.brc = '0;
        end else begin
            m.hi = 1; m.lui = 1; m.aui = 1; m.aa = 1;
            if (i[6:0] != 7'h63) m.aop = '1;
        end
    endfunction

    function automatic bit m_reads(input logic [31:0] i, input logic [4:0] r);
        bit r1, r2;
        r1 = i[6:0] inside {7'h13, 7'h33, 7'h03, 7'h23, 7'h63, 7'h67};
        r2 = i[6:0] inside {7'h33, 7'h23, 7'h63};
        return (r1 && i[19:15] == r) || (r2 && i[24:20] == r);
    endfunction

    function automatic bit m_hazard(input int d);
        bun_t e, m;
        if (!in_valid || !mv[d]) return 1'b0;
        mdec(mins[d], d == 1, e, m);
        return e.m2 && e.rd != 0 && m_reads(instr, e.rd);
    endfunction

    function automatic bit m_ready(input int d);
        return !(m_hazard(d) || cyc < mblk[d]) && (!mv[d] || ex_ready) && !flush;
    endfunction

    // After a hazard no instruction may issue before cycle (hazard cycle + LOAD_STALL).
    task automatic m_step();
        for (int d = 0; d < 2; d++) begin
            bit hz;
            hz = m_hazard(d);
            if (flush) begin mv[d] = 0; mblk[d] = 0; end
            else if (mv[d] && !ex_ready) begin end
            else if (hz) begin mv[d] = 0; mblk[d] = cyc + ls_of(d); end
            else if (cyc < mblk[d]) mv[d] = 0;
            else if (in_valid) begin mv[d] = 1; mins[d] = instr; end
            else mv[d] = 0;
        end
        cyc++;
    endtask

    task automatic drive(input bit iv, input logic [31:0] ins, input bit fl, input bit er);
        in_valid = iv; instr = ins; flush = fl; ex_ready = er;
    endtask

    task automatic cycle();
        bun_t e, m;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("in_ready[%0d]", d), 64'(ir_w[d]), 64'(m_ready(d)));
            if (mv[d]) begin
                mdec(mins[d], d == 1, e, m);
                chk($sformatf("bundle[%0d]", d), 64'(act[d] & m), 64'(e & m));
            end else begin
                chk($sformatf("out_valid[%0d]", d), 64'(act[d].ov), 64'(0));
            end
        end
        @(posedge clk);
        m_step();
        @(negedge clk);
    endtask

    task automatic reset_mid();
        #3 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_zero[%0d]", d), 64'(act[d]), 64'(0));
            chk($sformatf("rst_in_ready[%0d]", d), 64'(ir_w[d]), 64'(1));
            mv[d] = 0; mblk[d] = 0;
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rnd_ins();
        logic [6:0] opc[12] = '{7'h13, 7'h33, 7'h03, 7'h03, 7'h03, 7'h23, 7'h63,
                                7'h6F, 7'h67, 7'h37, 7'h17, 7'h03};
        logic [31:0] r;
        int k;
        r = $urandom;
        k = $urandom_range(0, 12);
        if (k < 12) r[6:0] = opc[k];
        r[11:7] = 5'($urandom_range(0, 3));
        r[19:15] = 5'($urandom_range(0, 3));
        r[24:20] = 5'($urandom_range(0, 3));
        return r;
    endfunction

    initial begin
        int first0, first1;
        tbl[0]  = '{32'h40208033, 0, 0, 0, 0, 0, 0, 3'd0, 1, 5'd0};  // sub x0,x1,x2
        tbl[1]  = '{32'h00A00093, 0, 0, 1, 0, 0, 1, 3'd0, 0, 5'd1};  // addi x1,x0,10
        tbl[2]  = '{32'h00010083, 1, 0, 0, 0, 0, 0, 3'd0, 0, 5'd1};  // lb x1,0(x2)
        tbl[3]  = '{32'h4050D093, 0, 0, 1, 0, 0, 1, 3'd5, 1, 5'd1};  // srai x1,x1,5
        tbl[4]  = '{32'h0020A023, 0, 0, 0, 1, 0, 1, 3'd0, 0, 5'd0};  // sw x2,0(x1)
        tbl[5]  = '{32'h00209023, 1, 0, 0, 0, 0, 0, 3'd0, 0, 5'd0};  // sh x2,0(x1)
        tbl[6]  = '{32'h0020B023, 1, 1, 0, 0, 0, 0, 3'd0, 0, 5'd0};  // store funct3=011
        tbl[7]  = '{32'h0000E083, 1, 1, 0, 0, 0, 0, 3'd0, 0, 5'd1};  // load funct3=110
        tbl[8]  = '{32'hFFFFFFFF, 1, 1, 0, 0, 0, 0, 3'd0, 0, 5'd31}; // unknown opcode
        tbl[9]  = '{32'h00A00090, 1, 1, 0, 0, 0, 0, 3'd0, 0, 5'd1};  // instr[1:0]=00
        tbl[10] = '{32'h00C000EF, 0, 0, 1, 0, 0, 0, 3'd0, 0, 5'd1};  // jal x1,12
        tbl[11] = '{32'h4020E133, 0, 0, 1, 0, 0, 0, 3'd6, 0, 5'd2};  // or with funct7[5]=1
        tbl[12] = '{32'h000012B7, 0, 0, 1, 0, 0, 1, 3'd0, 0, 5'd5};  // lui x5,1

        rst_n = 1'b0;
        drive(0, 32'h0, 0, 1);
        for (int d = 0; d < 2; d++) begin mv[d] = 0; mblk[d] = 0; mins[d] = '0; end
        @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset_state[%0d]", d), 64'(act[d]), 64'(0));
            chk($sformatf("reset_in_ready[%0d]", d), 64'(ir_w[d]), 64'(1));
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 13; k++) begin
            drive(1, tbl[k].ins, 0, 1);
            cycle();
            chk($sformatf("v%0d illegal0", k), 64'(ill_w[0]), 64'(tbl[k].ill0));
            chk($sformatf("v%0d illegal1", k), 64'(ill_w[1]), 64'(tbl[k].ill1));
            chk($sformatf("v%0d out_valid", k), 64'(ov_w[0]), 64'(1));
            chk($sformatf("v%0d rd", k), 64'(rd_w[0]), 64'(tbl[k].rd));
            chk($sformatf("v%0d we/mwe/m2rf", k), 64'({rw_w[0], mw_w[0], m2_w[0]}),
                64'({tbl[k].rf_we, tbl[k].mem_we, tbl[k].mem2rf}));
            if (!tbl[k].ill0)
                chk($sformatf("v%0d imm/aluop/alt", k), 64'({hi_w[0], aop_w[0], aa_w[0]}),
                    64'({tbl[k].has_imm, tbl[k].alu_op, tbl[k].alu_alt}));
            drive(0, 32'h0, 0, 1);
            cycle();
        end

        // load-use: dependent add issues LOAD_STALL cycles late
        drive(1, LW5, 0, 1);
        cycle();
        chk("lw held", 64'({ov_w[0], m2_w[0], rd_w[0], ov_w[1], m2_w[1], rd_w[1]}),
            64'({1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 5'd5}));
        drive(1, ADD6, 0, 1);
        first0 = -1; first1 = -1;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (first0 < 0 && ir_w[0]) first0 = k;
            if (first1 < 0 && ir_w[1]) first1 = k;
            if (k == 1) chk("bubble out_valid0", 64'(ov_w[0]), 64'(0));
            cycle();
        end
        chk("stall cycles LS=2", 64'(first0), 64'(LS0));
        chk("stall cycles LS=3", 64'(first1), 64'(LS1));
        chk("add after stall", 64'({ov_w[0], rd_w[0], ov_w[1], rd_w[1]}),
            64'({1'b1, 5'd6, 1'b1, 5'd6}));
        drive(0, 32'h0, 0, 1); cycle();

        // no false hazards: load to x0, and lui reading no register
        drive(1, 32'h0000A003, 0, 1); cycle();
        drive(1, 32'h00000333, 0, 1); #1;
        chk("lw x0 no stall", 64'({ir_w[0], ir_w[1]}), 64'(2'b11));
        cycle();
        drive(1, LW5, 0, 1); cycle();
        drive(1, 32'h000012B7, 0, 1); #1;
        chk("lui no stall", 64'({ir_w[0], ir_w[1]}), 64'(2'b11));
        cycle();
        chk("lui held", 64'({lui_w[0], lui_w[1]}), 64'(2'b11));
        drive(0, 32'h0, 0, 1); cycle();

        // backpressure holds the bundle
        drive(1, 32'h00A00093, 0, 1); cycle();
        drive(1, 32'h4020E133, 0, 0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp in_ready", 64'({ir_w[0], ir_w[1]}), 64'(0));
            cycle();
            chk("bp hold", 64'({ov_w[0], rd_w[0], hi_w[0]}), 64'({1'b1, 5'd1, 1'b1}));
        end
        drive(1, 32'h4020E133, 0, 1); cycle();
        chk("bp release", 64'({ov_w[0], rd_w[0]}), 64'({1'b1, 5'd2}));
        drive(0, 32'h0, 0, 1); cycle();

        // flush during an active stall
        drive(1, LW5, 0, 1); cycle();
        drive(1, ADD6, 0, 1); cycle();
        drive(1, ADD6, 1, 1); #1;
        chk("flush in_ready", 64'({ir_w[0], ir_w[1]}), 64'(0));
        cycle();
        chk("flush out_valid", 64'({ov_w[0], ov_w[1]}), 64'(0));
        drive(1, ADD6, 0, 1); #1;
        chk("post-flush ready", 64'({ir_w[0], ir_w[1]}), 64'(2'b11));
        cycle();
        chk("post-flush accept", 64'({ov_w[0], rd_w[0], ov_w[1], rd_w[1]}),
            64'({1'b1, 5'd6, 1'b1, 5'd6}));
        drive(0, 32'h0, 0, 1); cycle();

        // flush coinciding with a hazard leaves no bubble count
        drive(1, LW5, 0, 1); cycle();
        drive(1, ADD6, 1, 1); cycle();
        drive(1, ADD6, 0, 1); #1;
        chk("flush+hazard ready", 64'({ir_w[0], ir_w[1]}), 64'(2'b11));
        cycle();
        drive(0, 32'h0, 0, 1); cycle();

        // lb with and without sub-word support
        drive(1, 32'h00010083, 0, 1); cycle();
        chk("lb es0", 64'({ov_w[0], ill_w[0], rw_w[0], m2_w[0]}), 64'(4'b1100));
        chk("lb es1", 64'({ov_w[1], ill_w[1], rw_w[1], m2_w[1], ms_w[1]}), 64'(6'b101100));
        drive(0, 32'h0, 0, 1); cycle();

        // reset in the middle of a stall
        drive(1, LW5, 0, 1); cycle();
        drive(1, ADD6, 0, 1); cycle();
        reset_mid();
        drive(1, ADD6, 0, 1); #1;
        chk("post-reset ready", 64'(ir_w[1]), 64'(1));
        cycle();
        chk("post-reset accept", 64'({ov_w[1], rd_w[1]}), 64'({1'b1, 5'd6}));

        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 9) != 0, rnd_ins(), $urandom_range(0, 19) == 0,
                  $urandom_range(0, 4) != 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
